fp40_to_fp32_pack: RTL

Output packing stage downstream of the 40-bit-fraction floating-point adder in the sincos datapath. Accepts one internal-format result per handshake (sign, signed 8-bit exponent, 40-bit fraction), normalizes it, rounds it to nearest-even, and packs it as IEEE-754 binary32 with status flags. It is a two-stage valid/ready pipeline, so adder results can be registered and back-pressured before they leave the core.

---
 rtl/fp40_pkg.sv | 50 +++++
 rtl/fp40_to_fp32_pack_lzc40.sv | 22 ++
 rtl/fp40_to_fp32_pack.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fp40_pkg.sv
// Shared definitions for the 40-bit-fraction floating-point datapath:
// widths, binary32 constants and the internal {sign, exp, frac} triple.
package fp40_pkg;

    localparam int FRAC_WIDTH   = 40;
    localparam int EXP_WIDTH    = 8;
    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_MAX = 255;
    localparam int FP32_MANT_W  = 23;

    // Leading-zero count width and the widened exponent after normalization.
    localparam int LZC_WIDTH    = 6;
    localparam int NEXP_WIDTH   = EXP_WIDTH + 1;
    localparam int BIASED_WIDTH = EXP_WIDTH + 2;

    // Bit positions inside the normalized fraction (MSB is the integer bit).
    localparam int GUARD_BIT    = FRAC_WIDTH - 2 - FP32_MANT_W;

    // Internal-format value as produced by the adder stages.
    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [FRAC_WIDTH-1:0] frac;
    } fp40_t;

    // Normalized value held between the two pipeline stages. The integer
    // bit is always 1 for nonzero values, so only the bits below it are kept.
    typedef struct packed {
        logic                  sign;
        logic                  isZero;
        logic [NEXP_WIDTH-1:0] nexp;
        logic [FRAC_WIDTH-2:0] nfracLow;
    } fp40_norm_t;

    // Packed binary32 result together with its status flags.
    typedef struct packed {
        logic [31:0] fp32;
        logic        ovf;
        logic        unf;
        logic        inexact;
    } fp32_result_t;

    // Assembles a binary32 word from its three fields.
    function automatic logic [31:0] fp32Pack(input logic sign,
                                             input logic [7:0] bexp,
                                             input logic [FP32_MANT_W-1:0] mant);
        return {sign, bexp, mant};
    endfunction

endpackage

// File: rtl/fp40_to_fp32_pack_lzc40.sv
// Combinational leading-zero counter for a 40-bit fraction. The count is
// 0 when the input is all zero; o_allZero flags that case separately.
module lzc40
    import fp40_pkg::*;
(
    input  logic [FRAC_WIDTH-1:0] i_data,
    output logic [LZC_WIDTH-1:0]  o_count,
    output logic                  o_allZero
);

    // Scan from LSB upward so the highest set bit writes the final count.
    always_comb begin
        o_count   = '0;
        o_allZero = (i_data == '0);
        for (int i = 0; i < FRAC_WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = LZC_WIDTH'(FRAC_WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp40_to_fp32_pack.sv
// Output packing stage: normalizes an internal 40-bit-fraction result,
// rounds it to nearest-even and packs it as binary32 with status flags.
// Two valid/ready register stages allow back-pressure from downstream.
module fp40_to_fp32_pack
    import fp40_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_sign,
    input  logic [EXP_WIDTH-1:0]  i_exp,
    input  logic [FRAC_WIDTH-1:0] i_frac,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [31:0]           o_fp32,
    output logic                  o_ovf,
    output logic                  o_unf,
    output logic                  o_inexact
);

    logic [LZC_WIDTH-1:0]    w_lz;
    logic                    w_allZero;
    logic [FRAC_WIDTH-2:0]   w_nfracLow;
    logic [NEXP_WIDTH-1:0]   w_nexp;
    fp40_norm_t              w_s1Next;

    logic                    r_s1Valid;
    fp40_norm_t              r_s1;

    logic [FP32_MANT_W-1:0]  w_mant;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_roundUp;
    logic [FP32_MANT_W:0]    w_mantSum;
    logic                    w_carry;
    logic [FP32_MANT_W-1:0]  w_mantRnd;
    logic [BIASED_WIDTH-1:0] w_biased;
    fp32_result_t            w_result;

    logic                    r_oValid;
    fp32_result_t            r_result;

    logic                    w_adv1;
    logic                    w_adv2;

    lzc40 u_lzc (
        .i_data    (i_frac),
        .o_count   (w_lz),
        .o_allZero (w_allZero)
    );

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        w_adv2  = !r_oValid || i_ready;
        w_adv1  = !r_s1Valid || w_adv2;
        o_ready = w_adv1;
    end

    // Stage 1 normalization: shift the leading one into the integer bit and
    // compensate the exponent. The integer bit itself is dropped here.
    always_comb begin
        w_nfracLow        = (FRAC_WIDTH-1)'(i_frac << w_lz);
        w_nexp            = {i_exp[EXP_WIDTH-1], i_exp} - {3'b000, w_lz};
        w_s1Next          = '0;
        w_s1Next.sign     = i_sign;
        w_s1Next.isZero   = w_allZero;
        w_s1Next.nexp     = w_nexp;
        w_s1Next.nfracLow = w_nfracLow;
    end

    // Stage 1 register: holds one normalized beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1Valid <= 1'b0;
            r_s1      <= '0;
        end else if (w_adv1) begin
            r_s1Valid <= i_valid;
            if (i_valid) begin
                r_s1 <= w_s1Next;
            end
        end
    end

    // Stage 2 rounding: round-to-nearest-even on the 23-bit mantissa. A carry
    // out leaves the mantissa at zero and bumps the exponent by one.
    always_comb begin
        w_mant    = r_s1.nfracLow[FRAC_WIDTH-2 -: FP32_MANT_W];
        w_guard   = r_s1.nfracLow[GUARD_BIT];
        w_sticky  = |r_s1.nfracLow[GUARD_BIT-1:0];
        w_roundUp = w_guard && (w_sticky || w_mant[0]);
        w_mantSum = {1'b0, w_mant} + {{FP32_MANT_W{1'b0}}, w_roundUp};
        w_carry   = w_mantSum[FP32_MANT_W];
        w_mantRnd = w_mantSum[FP32_MANT_W-1:0];
        w_biased  = {r_s1.nexp[NEXP_WIDTH-1], r_s1.nexp}
                  + BIASED_WIDTH'(FP32_BIAS)
                  + {{(BIASED_WIDTH-1){1'b0}}, w_carry};
    end

    // Stage 2 packing: zero first, then overflow to Inf, then flush to zero,
    // otherwise a normal binary32. Denormals and NaN are never produced.
    always_comb begin
        w_result = '0;
        if (r_s1.isZero) begin
            w_result.fp32 = fp32Pack(r_s1.sign, 8'h00, '0);
        end else if ($signed(w_biased) >= $signed(BIASED_WIDTH'(FP32_EXP_MAX))) begin
            w_result.fp32    = fp32Pack(r_s1.sign, 8'hFF, '0);
            w_result.ovf     = 1'b1;
            w_result.inexact = 1'b1;
        end else if ($signed(w_biased) <= $signed(BIASED_WIDTH'(0))) begin
            w_result.fp32    = fp32Pack(r_s1.sign, 8'h00, '0);
            w_result.unf     = 1'b1;
            w_result.inexact = 1'b1;
        end else begin
            w_result.fp32    = fp32Pack(r_s1.sign, w_biased[7:0], w_mantRnd);
            w_result.inexact = w_guard || w_sticky;
        end
    end

    // Stage 2 register: drives the outputs and holds them while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_oValid <= 1'b0;
            r_result <= '0;
        end else if (w_adv2) begin
            r_oValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_result <= w_result;
            end
        end
    end

    assign o_valid   = r_oValid;
    assign o_fp32    = r_result.fp32;
    assign o_ovf     = r_result.ovf;
    assign o_unf     = r_result.unf;
    assign o_inexact = r_result.inexact;

endmodule
